rr_byte_arbiter: RTL and testbench

- Two-input round-robin arbiter for byte streams.
- Feeds the 8-bit 2:1 select datapath: decides, per accepted transfer, which of two valid/ready sources wins.
- Captures the selected byte plus its source tag in a 2-entry output FIFO.
- Downstream sees a single valid/ready byte stream with fair interleaving and 1-cycle latency.

---
 rtl/rr_byte_arbiter_pkg.sv | 10 +
 rtl/rr_byte_arbiter_if.sv | 31 +++
 rtl/rr_byte_arbiter_fifo2_tagged.sv | 47 ++++
 rtl/rr_byte_arbiter.sv | 54 +++++
 tb/tb_rr_byte_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_byte_arbiter_pkg.sv
// Shared constants for the two-source round-robin byte arbiter.
// Source tags double as the priority pointer encoding.
package rr_byte_arbiter_pkg;

    localparam int   DATA_WIDTH = 8;
    localparam logic SRC_A      = 1'b0;
    localparam logic SRC_B      = 1'b1;
    localparam int   FIFO_DEPTH = 2;

endpackage

// File: rtl/rr_byte_arbiter_if.sv
// Handshake bundle for the arbiter: two valid/ready sources in, one tagged byte stream out.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface rr_byte_arbiter_if
    import rr_byte_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic [1:0]       level;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, level
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, level
    );

endinterface

// File: rtl/rr_byte_arbiter_fifo2_tagged.sv
// Two-entry FIFO of {src, data}; entry 0 is always the head, so dout needs no read mux.
// Push into a full FIFO and pop from an empty one are ignored.
module fifo2_tagged
    import rr_byte_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic [WIDTH:0] din,
    output logic [WIDTH:0] dout,
    output logic [1:0]     level
);

    logic [WIDTH:0] mem [FIFO_DEPTH];
    logic           do_push;
    logic           do_pop;

    assign do_push = push && (level < 2'(FIFO_DEPTH));
    assign do_pop  = pop && (level != 2'd0);

    // A pop shifts entry 1 forward; a push lands in whichever slot becomes the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            level  <= 2'd0;
        end else begin
            if (do_pop) begin
                mem[0] <= mem[1];
            end
            if (do_push) begin
                if ((level == 2'd0) || (level == 2'd1 && do_pop)) begin
                    mem[0] <= din;
                end else begin
                    mem[1] <= din;
                end
            end
            level <= level + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout = mem[0];

endmodule

// File: rtl/rr_byte_arbiter.sv
// Round-robin arbiter between two byte sources feeding a 2-entry tagged output FIFO.
// The priority pointer flips to the losing source on every grant.
module rr_byte_arbiter
    import rr_byte_arbiter_pkg::*;
#(
    parameter int   WIDTH      = DATA_WIDTH,
    parameter logic PRIO_RESET = SRC_A
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_byte_arbiter_if.slave    bus
);

    logic             prio;
    logic             space;
    logic             grant_a;
    logic             grant_b;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH:0]   head;

    // No pass-through: a full FIFO refuses input even when it pops this cycle.
    assign space   = bus.level < 2'(FIFO_DEPTH);
    assign grant_a = rst_n & space & bus.a_valid & ((prio == SRC_A) | ~bus.b_valid);
    assign grant_b = rst_n & space & bus.b_valid & ((prio == SRC_B) | ~bus.a_valid);

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;
    assign sel_data    = grant_b ? bus.b_data : bus.a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PRIO_RESET;
        end else if (grant_a | grant_b) begin
            prio <= grant_a ? SRC_B : SRC_A;
        end
    end

    fifo2_tagged #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant_a | grant_b),
        .pop   (bus.out_valid & bus.out_ready),
        .din   ({grant_b, sel_data}),
        .dout  (head),
        .level (bus.level)
    );

    assign bus.out_valid = (bus.level != 2'd0);
    assign bus.out_src   = head[WIDTH];
    assign bus.out_data  = head[WIDTH-1:0];

endmodule

// File: tb/tb_rr_byte_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
// A second instance with PRIO_RESET=1 checks the reset-time preference of source B.
module tb_rr_byte_arbiter;

    logic clk;
    logic rst_n;

    rr_byte_arbiter_if #(.WIDTH(8)) bus0 ();
    rr_byte_arbiter_if #(.WIDTH(8)) bus1 ();

    rr_byte_arbiter #(.WIDTH(8), .PRIO_RESET(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    rr_byte_arbiter #(.WIDTH(8), .PRIO_RESET(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [8:0]  mq[$];
    logic        mprio;
    logic        expA;
    logic        expB;
    logic [7:0]  ai;
    logic [7:0]  bi;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [7:0] ad, input logic bv,
                                 input logic [7:0] bd, input logic ordy);
        @(negedge clk);
        bus0.a_valid   = av;
        bus0.a_data    = ad;
        bus0.b_valid   = bv;
        bus0.b_data    = bd;
        bus0.out_ready = ordy;
    endtask

    // Model: a source with data wins if it is alone or preferred, provided the queue has room.
    task automatic checkOutput();
        expA = 1'b0;
        expB = 1'b0;
        if (mq.size() < 2) begin
            if (bus0.a_valid && bus0.b_valid) begin
                if (mprio) expB = 1'b1;
                else       expA = 1'b1;
            end else begin
                expA = bus0.a_valid;
                expB = bus0.b_valid;
            end
        end
        check("a_ready", {8'd0, bus0.a_ready}, {8'd0, expA});
        check("b_ready", {8'd0, bus0.b_ready}, {8'd0, expB});
        check("level", {7'd0, bus0.level}, 9'(mq.size()));
        check("out_valid", {8'd0, bus0.out_valid}, {8'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("out_head", {bus0.out_src, bus0.out_data}, mq[0]);
        end
    endtask

    task automatic modelUpdate();
        if (mq.size() != 0 && bus0.out_ready) begin
            void'(mq.pop_front());
        end
        if (expA) begin
            mq.push_back({1'b0, bus0.a_data});
            mprio = 1'b1;
        end else if (expB) begin
            mq.push_back({1'b1, bus0.b_data});
            mprio = 1'b0;
        end
    endtask

    task automatic step(input logic av, input logic [7:0] ad, input logic bv,
                        input logic [7:0] bd, input logic ordy);
        applyStimulus(av, ad, bv, bd, ordy);
        #1;
        checkOutput();
        modelUpdate();
        @(posedge clk);
    endtask

    // Reset is asserted with both sources still requesting to prove the readies are forced low.
    task automatic doReset();
        @(negedge clk);
        bus0.a_valid = 1'b1;
        bus0.b_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_a_ready", {8'd0, bus0.a_ready}, 9'd0);
        check("rst_b_ready", {8'd0, bus0.b_ready}, 9'd0);
        check("rst_out_valid", {8'd0, bus0.out_valid}, 9'd0);
        check("rst_level", {7'd0, bus0.level}, 9'd0);
        mq.delete();
        mprio = 1'b0;
        @(negedge clk);
        bus0.a_valid   = 1'b0;
        bus0.b_valid   = 1'b0;
        bus0.out_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        mprio = 1'b0;
        rst_n = 1'b0;
        bus0.a_valid = 1'b1; bus0.a_data = 8'h3C; bus0.b_valid = 1'b1; bus0.b_data = 8'hC3;
        bus0.out_ready = 1'b0;
        bus1.a_valid = 1'b0; bus1.a_data = 8'h00; bus1.b_valid = 1'b0; bus1.b_data = 8'h00;
        bus1.out_ready = 1'b0;
        #3;
        check("init_a_ready", {8'd0, bus0.a_ready}, 9'd0);
        check("init_b_ready", {8'd0, bus0.b_ready}, 9'd0);
        check("init_out_valid", {8'd0, bus0.out_valid}, 9'd0);
        check("init_head", {bus0.out_src, bus0.out_data}, 9'd0);
        check("init_level", {7'd0, bus0.level}, 9'd0);
        @(negedge clk);
        bus0.a_valid = 1'b0;
        bus0.b_valid = 1'b0;
        rst_n = 1'b1;

        // Source A alone, back to back.
        step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        #1 check("a_only_head0", {bus0.out_src, bus0.out_data}, 9'h011);
        step(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
        #1 check("a_only_head1", {bus0.out_src, bus0.out_data}, 9'h022);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Both sources streaming from a fresh reset: A0,B0,A1,B1.
        doReset();
        ai = 8'hA0;
        bi = 8'hB0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ai, 1'b1, bi, 1'b1);
            if (expA) ai++;
            if (expB) bi++;
        end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Backpressure fills the FIFO, then draining lets the third byte in.
        ai = 8'h01;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ai, 1'b0, 8'h00, 1'b0);
            if (expA) ai++;
        end
        #1 check("full_head", {bus0.out_src, bus0.out_data}, 9'h001);
        for (int i = 0; i < 3; i++) begin
            step(ai <= 8'h03, ai, 1'b0, 8'h00, 1'b1);
            if (expA) ai++;
        end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Simultaneous push and pop at level 1.
        step(1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        #1 check("pushpop_level", {7'd0, bus0.level}, 9'd1);
        check("pushpop_head", {bus0.out_src, bus0.out_data}, 9'h055);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Fill to level 2, then reset mid-stream.
        step(1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        #1 check("pre_reset_level", {7'd0, bus0.level}, 9'd2);
        doReset();

        // Instance with PRIO_RESET=1: B wins the first contested cycle, A the next.
        bus1.a_valid = 1'b1; bus1.a_data = 8'h5A;
        bus1.b_valid = 1'b1; bus1.b_data = 8'h6B;
        bus1.out_ready = 1'b1;
        #1;
        check("p1_b_first", {7'd0, bus1.b_ready, bus1.a_ready}, 9'b10);
        @(negedge clk);
        #1;
        check("p1_head", {bus1.out_src, bus1.out_data}, 9'h16B);
        check("p1_a_next", {7'd0, bus1.b_ready, bus1.a_ready}, 9'b01);
        bus1.a_valid = 1'b0;
        bus1.b_valid = 1'b0;

        // After reset the PRIO_RESET=0 instance favours A again.
        step(1'b1, 8'h81, 1'b1, 8'h91, 1'b1);
        step(1'b1, 8'h82, 1'b1, 8'h92, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
